// File: rtl/data_pack_pkg.sv
// Shared definitions for the symbol pack/unpack stages.
// Width defaults live here so both stages agree on the bitstream layout.
package data_pack_pkg;

  localparam int DEF_SYM_W  = 7;
  localparam int DEF_WORD_W = 32;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } pack_state_t;

endpackage

// File: rtl/data_pack_if.sv
// Symbol-in / word-out handshake bundle for the packer.
// The slave side is the packer itself; the master side is whoever drives symbols and takes words.
interface data_pack_if
  import data_pack_pkg::*;
#(
  parameter int SYM_W  = DEF_SYM_W,
  parameter int WORD_W = DEF_WORD_W
) ();

  localparam int FW = $clog2(WORD_W);

  logic [SYM_W-1:0]  in_data;
  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              flush_done;
  logic [FW-1:0]     fill;

  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output in_ready, out_data, out_valid, flush_done, fill
  );

  modport master (
    output in_data, in_valid, flush, out_ready,
    input  in_ready, out_data, out_valid, flush_done, fill
  );

endinterface

// File: rtl/data_pack_datapath.sv
// Packs an LSB-first stream of SYM_W-bit symbols into WORD_W-bit words.
// A flush drains residual bits as a zero-padded word, then pulses flush_done.
module data_pack_datapath
  import data_pack_pkg::*;
#(
  parameter int SYM_W  = DEF_SYM_W,
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic       clk,
  input  logic       rst,
  data_pack_if.slave bus
);

  localparam int FW    = $clog2(WORD_W);
  localparam int ACC_W = WORD_W + SYM_W - 1;

  localparam logic [FW:0] SYM_W_E  = (FW+1)'(SYM_W);
  localparam logic [FW:0] WORD_W_E = (FW+1)'(WORD_W);

  pack_state_t       state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              flush_done_q, flush_done_d;

  logic              slot_free;
  logic              complete;
  logic              in_ready;
  logic              accept;
  logic [FW:0]       fill_sum;
  logic [FW:0]       fill_wrap;
  logic [ACC_W-1:0]  merged;
  logic [WORD_W-1:0] pad_mask;

  assign slot_free = !out_valid_q || bus.out_ready;
  assign fill_sum  = {1'b0, fill_q} + SYM_W_E;
  assign fill_wrap = fill_sum - WORD_W_E;
  assign complete  = (fill_sum >= WORD_W_E);
  assign merged    = acc_q | (ACC_W'(bus.in_data) << fill_q);
  assign pad_mask  = (WORD_W'(1) << fill_q) - WORD_W'(1);
  assign accept    = bus.in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (bus.flush) state_d = S_FLUSH;
      S_FLUSH: if (fill_q == '0) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // A completing symbol must wait for the output slot; others never do.
  always_comb begin
    in_ready = 1'b0;
    if (state_q == S_RUN) in_ready = !(complete && !slot_free);
  end

  always_comb begin
    acc_d        = acc_q;
    fill_d       = fill_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    flush_done_d = 1'b0;

    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

    if (state_q == S_RUN) begin
      if (accept) begin
        if (complete) begin
          out_data_d  = merged[WORD_W-1:0];
          out_valid_d = 1'b1;
          acc_d       = merged >> WORD_W;
          fill_d      = fill_wrap[FW-1:0];
        end else begin
          acc_d  = merged;
          fill_d = fill_sum[FW-1:0];
        end
      end
    end else begin
      if (fill_q != '0) begin
        if (slot_free) begin
          out_data_d  = acc_q[WORD_W-1:0] & pad_mask;
          out_valid_d = 1'b1;
          acc_d       = '0;
          fill_d      = '0;
        end
      end else begin
        flush_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q        <= '0;
      fill_q       <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.flush_done = flush_done_q;
  assign bus.fill       = fill_q;

endmodule

// File: tb/tb_data_pack_datapath.sv
// Directed bench for the symbol packer: full words, flush, stall, stream ordering and reset.
module tb_data_pack_datapath;
  import data_pack_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   timeouts;
  logic [31:0] got_q[$];

  data_pack_if bus ();

  data_pack_datapath dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Record every word the downstream side takes.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic push(input logic [6:0] d);
    bit ok;
    ok = 1'b0;
    bus.in_data = d;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!ok) timeouts++;
  endtask

  task automatic test_reset();
    bus.out_ready = 1'b1;
    do_reset();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.fill !== 5'd0) begin failures++; $display("FAIL rst_fill got=%0d exp=0", bus.fill); end
    checks++; if (bus.out_data !== 32'h0) begin failures++; $display("FAIL rst_out_data got=%h exp=0", bus.out_data); end
    checks++; if (bus.flush_done !== 1'b0) begin failures++; $display("FAIL rst_flush_done got=%b exp=0", bus.flush_done); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_full_word();
    for (int i = 0; i < 4; i++) push(7'h7F);
    checks++; if (bus.fill !== 5'd28) begin failures++; $display("FAIL t1_fill28 got=%0d exp=28", bus.fill); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL t1_early_valid got=%b exp=0", bus.out_valid); end
    push(7'h7F);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL t1_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_data !== 32'hFFFF_FFFF) begin failures++; $display("FAIL t1_word got=%h exp=ffffffff", bus.out_data); end
    checks++; if (bus.fill !== 5'd3) begin failures++; $display("FAIL t1_fill3 got=%0d exp=3", bus.fill); end
  endtask

  task automatic test_flush();
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL t2_in_ready got=%b exp=0", bus.in_ready); end
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL t2_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_data !== 32'h0000_0007) begin failures++; $display("FAIL t2_word got=%h exp=00000007", bus.out_data); end
    checks++; if (bus.fill !== 5'd0) begin failures++; $display("FAIL t2_fill got=%0d exp=0", bus.fill); end
    @(posedge clk); #1;
    checks++; if (bus.flush_done !== 1'b1) begin failures++; $display("FAIL t2_done got=%b exp=1", bus.flush_done); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL t2_ready_back got=%b exp=1", bus.in_ready); end
    @(posedge clk); #1;
    checks++; if (bus.flush_done !== 1'b0) begin failures++; $display("FAIL t2_done_pulse got=%b exp=0", bus.flush_done); end
  endtask

  task automatic test_back_to_back();
    logic [223:0] exp_stream;
    logic [223:0] got_stream;
    do_reset();
    got_q.delete();
    exp_stream = '0;
    got_stream = '0;
    for (int k = 0; k < 32; k++) exp_stream[7*k +: 7] = 7'(k);
    for (int k = 0; k < 32; k++) push(7'(k));
    @(posedge clk); #1;
    checks++; if (got_q.size() !== 7) begin failures++; $display("FAIL t3_count got=%0d exp=7", got_q.size()); end
    checks++; if (bus.fill !== 5'd0) begin failures++; $display("FAIL t3_fill got=%0d exp=0", bus.fill); end
    for (int n = 0; n < 7 && n < got_q.size(); n++) got_stream[32*n +: 32] = got_q[n];
    checks++; if (got_stream[31:0] !== 32'h4060_8080) begin failures++; $display("FAIL t3_word0 got=%h exp=40608080", got_stream[31:0]); end
    for (int n = 0; n < 7; n++) begin
      checks++;
      if (got_stream[32*n +: 32] !== exp_stream[32*n +: 32]) begin
        failures++; $display("FAIL t3_word%0d got=%h exp=%h", n, got_stream[32*n +: 32], exp_stream[32*n +: 32]);
      end
    end
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (got_stream[7*k +: 7] !== 7'(k)) begin
        failures++; $display("FAIL t3_unpack%0d got=%h exp=%h", k, got_stream[7*k +: 7], 7'(k));
      end
    end
    checks++; if (timeouts !== 0) begin failures++; $display("FAIL t3_timeouts got=%0d exp=0", timeouts); end
  endtask

  task automatic test_stall();
    bit done_seen;
    do_reset();
    got_q.delete();
    bus.out_ready = 1'b0;
    push(7'h01); push(7'h02); push(7'h03); push(7'h04);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 10 && !done_seen; i++) begin
      @(posedge clk); #1;
      done_seen = bus.flush_done;
    end
    checks++; if (done_seen !== 1'b1) begin failures++; $display("FAIL t4_flush_done got=%b exp=1", done_seen); end
    push(7'h05); push(7'h06); push(7'h07); push(7'h08);
    checks++; if (bus.fill !== 5'd28) begin failures++; $display("FAIL t4_fill28 got=%0d exp=28", bus.fill); end
    bus.in_data = 7'h7F;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL t4_blocked got=%b exp=0", bus.in_ready); end
      checks++; if (bus.out_data !== 32'h0080_C101) begin failures++; $display("FAIL t4_hold got=%h exp=0080c101", bus.out_data); end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL t4_release got=%b exp=1", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL t4_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_data !== 32'hF101_C305) begin failures++; $display("FAIL t4_word1 got=%h exp=f101c305", bus.out_data); end
    checks++; if (bus.fill !== 5'd3) begin failures++; $display("FAIL t4_fill3 got=%0d exp=3", bus.fill); end
    @(posedge clk); #1;
    checks++; if (got_q.size() !== 2) begin failures++; $display("FAIL t4_count got=%0d exp=2", got_q.size()); end
    if (got_q.size() == 2) begin
      checks++; if (got_q[0] !== 32'h0080_C101) begin failures++; $display("FAIL t4_got0 got=%h exp=0080c101", got_q[0]); end
      checks++; if (got_q[1] !== 32'hF101_C305) begin failures++; $display("FAIL t4_got1 got=%h exp=f101c305", got_q[1]); end
    end
  endtask

  task automatic test_flush_edges();
    do_reset();
    bus.out_ready = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    checks++; if (bus.flush_done !== 1'b0) begin failures++; $display("FAIL t5_done_early got=%b exp=0", bus.flush_done); end
    @(posedge clk); #1;
    checks++; if (bus.flush_done !== 1'b1) begin failures++; $display("FAIL t5_done got=%b exp=1", bus.flush_done); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL t5_no_word got=%b exp=0", bus.out_valid); end

    do_reset();
    for (int i = 0; i < 4; i++) push(7'h7F);
    bus.in_data = 7'h7F;
    bus.in_valid = 1'b1;
    bus.flush = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL t5_accept got=%b exp=1", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    checks++; if (bus.out_data !== 32'hFFFF_FFFF) begin failures++; $display("FAIL t5_full got=%h exp=ffffffff", bus.out_data); end
    checks++; if (bus.fill !== 5'd3) begin failures++; $display("FAIL t5_fill3 got=%0d exp=3", bus.fill); end
    @(posedge clk); #1;
    checks++; if (bus.out_data !== 32'h0000_0007) begin failures++; $display("FAIL t5_resid got=%h exp=00000007", bus.out_data); end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL t5_resid_valid got=%b exp=1", bus.out_valid); end
    @(posedge clk); #1;
    checks++; if (bus.flush_done !== 1'b1) begin failures++; $display("FAIL t5_done2 got=%b exp=1", bus.flush_done); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(7'h7F);
    checks++; if (bus.fill !== 5'd10) begin failures++; $display("FAIL t6_fill10 got=%0d exp=10", bus.fill); end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL t6_pending got=%b exp=1", bus.out_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL t6_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.fill !== 5'd0) begin failures++; $display("FAIL t6_fill got=%0d exp=0", bus.fill); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL t6_ready got=%b exp=1", bus.in_ready); end
    bus.out_ready = 1'b1;
    push(7'h01); push(7'h02); push(7'h03); push(7'h04); push(7'h05);
    checks++; if (bus.out_data !== 32'h5080_C101) begin failures++; $display("FAIL t6_word got=%h exp=5080c101", bus.out_data); end
    checks++; if (timeouts !== 0) begin failures++; $display("FAIL t6_timeouts got=%0d exp=0", timeouts); end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    checks = 0;
    failures = 0;
    timeouts = 0;
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_full_word();
    test_flush();
    test_back_to_back();
    test_stall();
    test_flush_edges();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
